// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EXE stage: sequences multiplies internally and divides through an external divider.
// Optional build macro MULDIV_DIVZERO_BYPASS_EN completes zero-divisor divides locally without the divider.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    output logic        op_done,
    input  logic        flush,
    output logic        div_req_valid,
    input  logic        div_req_ready,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_resp_valid,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_REQ  = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [31:0] src1_r;
    logic [31:0] src2_r;
    logic        signed_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;
    logic        hi_we_s;
    logic        lo_we_s;
    logic        done_s;
    logic        op_ready_s;
    logic        accept_s;
    logic        op_signed_s;
    logic [63:0] prod_s;

    // Widen an operand to 64 bits so the low half of a 64x64 product is the exact 32x32 result.
    function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
        ext64 = sgn ? {{32{v[31]}}, v} : {32'd0, v};
    endfunction

    assign op_ready_s  = (state_r == S_IDLE) && !flush;
    assign accept_s    = op_valid && op_ready_s;
    assign op_signed_s = (op_type == OP_MULT) || (op_type == OP_DIV);
    assign prod_s      = ext64(src1_r, signed_r) * ext64(src2_r, signed_r);

    // Next-state, HI/LO write selection and completion strobe.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_s      = 1'b0;
        hi_we_s     = 1'b0;
        lo_we_s     = 1'b0;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    case (op_type)
                        OP_MULT, OP_MULTU: begin
                            state_nxt_s = S_MUL;
                            cnt_nxt_s   = CNT_INIT;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIVZERO_BYPASS_EN
                            if (op_src2 == 32'd0) begin
                                done_s   = 1'b1;
                                hi_we_s  = 1'b1;
                                lo_we_s  = 1'b1;
                                hi_nxt_s = op_src1;
                                lo_nxt_s = 32'hFFFF_FFFF;
                            end else begin
                                state_nxt_s = S_DIV_REQ;
                            end
`else
                            state_nxt_s = S_DIV_REQ;
`endif
                        end
                        OP_MTHI: begin
                            done_s   = 1'b1;
                            hi_we_s  = 1'b1;
                            hi_nxt_s = op_src1;
                        end
                        OP_MTLO: begin
                            done_s   = 1'b1;
                            lo_we_s  = 1'b1;
                            lo_nxt_s = op_src1;
                        end
                        default: done_s = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_nxt_s = S_IDLE;
                end else if (cnt_r == 3'd0) begin
                    done_s      = 1'b1;
                    hi_we_s     = 1'b1;
                    lo_we_s     = 1'b1;
                    hi_nxt_s    = prod_s[63:32];
                    lo_nxt_s    = prod_s[31:0];
                    state_nxt_s = S_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            S_DIV_REQ: begin
                // Once the divider has taken the request, a flush must still wait for its answer.
                if (div_req_ready) begin
                    state_nxt_s = flush ? S_DRAIN : S_DIV_WAIT;
                end else if (flush) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DIV_REQ;
                end
            end
            S_DIV_WAIT: begin
                if (flush) begin
                    state_nxt_s = div_resp_valid ? S_IDLE : S_DRAIN;
                end else if (div_resp_valid) begin
                    done_s      = 1'b1;
                    hi_we_s     = 1'b1;
                    lo_we_s     = 1'b1;
                    hi_nxt_s    = div_rem;
                    lo_nxt_s    = div_quot;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DIV_WAIT;
                end
            end
            S_DRAIN: begin
                if (div_resp_valid) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State and multiply countdown registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Operand capture on accept; held stable for the multiplier and the divider request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src1_r   <= 32'd0;
            src2_r   <= 32'd0;
            signed_r <= 1'b0;
        end else if (accept_s) begin
            src1_r   <= op_src1;
            src2_r   <= op_src2;
            signed_r <= op_signed_s;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (hi_we_s) begin
                hi_r <= hi_nxt_s;
            end
            if (lo_we_s) begin
                lo_r <= lo_nxt_s;
            end
        end
    end

    assign op_ready      = op_ready_s;
    assign op_done       = done_s;
    assign busy          = (state_r != S_IDLE);
    assign div_req_valid = (state_r == S_DIV_REQ);
    assign div_signed    = signed_r;
    assign div_dividend  = src1_r;
    assign div_divisor   = src2_r;
    assign hi            = hi_r;
    assign lo            = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: three instances (MUL_LAT 1, 2, 8), a transaction-level model and
// a per-cycle compare process. Honours MULDIV_DIVZERO_BYPASS_EN when the build defines it.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        flush;
    logic        div_req_ready;
    logic        div_resp_valid;
    logic [31:0] div_quot;
    logic [31:0] div_rem;
    int          sel;

    logic [2:0]  v_ready, v_done, v_req, v_sgn, v_busy;
    logic [31:0] v_dvd [3];
    logic [31:0] v_dvs [3];
    logic [31:0] v_hi  [3];
    logic [31:0] v_lo  [3];

    logic        d_ready, d_done, d_req, d_sgn, d_busy;
    logic [31:0] d_dvd, d_dvs, d_hi, d_lo;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        muldiv_ctrl #(.MUL_LAT(g == 0 ? 1 : (g == 1 ? 2 : 8))) u_dut (
            .clk           (clk),
            .reset         (reset),
            .op_valid      (op_valid && (sel == g)),
            .op_ready      (v_ready[g]),
            .op_type       (op_type),
            .op_src1       (op_src1),
            .op_src2       (op_src2),
            .op_done       (v_done[g]),
            .flush         (flush && (sel == g)),
            .div_req_valid (v_req[g]),
            .div_req_ready (div_req_ready && (sel == g)),
            .div_signed    (v_sgn[g]),
            .div_dividend  (v_dvd[g]),
            .div_divisor   (v_dvs[g]),
            .div_resp_valid(div_resp_valid && (sel == g)),
            .div_quot      (div_quot),
            .div_rem       (div_rem),
            .hi            (v_hi[g]),
            .lo            (v_lo[g]),
            .busy          (v_busy[g])
        );
    end

    always_comb begin
        d_ready = v_ready[sel];
        d_done  = v_done[sel];
        d_req   = v_req[sel];
        d_sgn   = v_sgn[sel];
        d_busy  = v_busy[sel];
        d_dvd   = v_dvd[sel];
        d_dvs   = v_dvs[sel];
        d_hi    = v_hi[sel];
        d_lo    = v_lo[sel];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi [3];
    logic [31:0] m_lo [3];
    logic        e_ready, e_done, e_busy, e_req, e_sgn;
    logic [31:0] e_dvd, e_dvs;
    bit          chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t dut=%0d actual=%h required=%h", name, $time, sel, act, exp);
        end
    endtask

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("op_ready", {31'd0, d_ready}, {31'd0, e_ready});
            cmp("op_done", {31'd0, d_done}, {31'd0, e_done});
            cmp("busy", {31'd0, d_busy}, {31'd0, e_busy});
            cmp("div_req_valid", {31'd0, d_req}, {31'd0, e_req});
            cmp("hi", d_hi, m_hi[sel]);
            cmp("lo", d_lo, m_lo[sel]);
            if (e_req) begin
                cmp("div_signed", {31'd0, d_sgn}, {31'd0, e_sgn});
                cmp("div_dividend", d_dvd, e_dvd);
                cmp("div_divisor", d_dvs, e_dvs);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 8);
    endfunction

    function automatic logic [63:0] prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Bench-side divider: returns {remainder, quotient}; for a zero divisor an arbitrary pattern.
    function automatic logic [63:0] divres(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a ^ 32'h5A5A_5A5A, ~a};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(5, 0))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        op_valid       = 1'b0;
        op_type        = 3'($urandom());
        op_src1        = $urandom();
        op_src2        = $urandom();
        flush          = 1'b0;
        div_req_ready  = 1'b0;
        div_resp_valid = 1'b0;
        div_quot       = $urandom();
        div_rem        = $urandom();
    endtask

    task automatic expect_c(input logic rdy, input logic done, input logic bsy, input logic req);
        e_ready = rdy;
        e_done  = done;
        e_busy  = bsy;
        e_req   = req;
    endtask

    task automatic idle_cycle(input bit noise);
        quiet();
        if (noise) begin
            flush          = ($urandom_range(3, 0) == 0);
            op_valid       = flush;
            div_resp_valid = ($urandom_range(2, 0) == 0);
            div_req_ready  = 1'($urandom());
        end
        expect_c(!flush, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic single_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        quiet();
        op_valid = 1'b1;
        op_type = t;
        op_src1 = a;
        op_src2 = b;
        div_resp_valid = 1'($urandom());
        expect_c(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        if (t == 3'd4) m_hi[sel] = a;
        if (t == 3'd5) m_lo[sel] = a;
    endtask

    task automatic mul_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int flush_k);
        int L;
        logic [63:0] p;
        L = lat_of(sel);
        quiet();
        op_valid = 1'b1;
        op_type = sgn ? 3'd0 : 3'd1;
        op_src1 = a;
        op_src2 = b;
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= L; k++) begin
            quiet();
            op_valid = 1'($urandom());
            div_resp_valid = 1'($urandom());
            if (k == flush_k) begin
                flush = 1'b1;
                expect_c(1'b0, 1'b0, 1'b1, 1'b0);
                step();
                return;
            end
            expect_c(1'b0, k == L, 1'b1, 1'b0);
            step();
        end
        p = prod(sgn, a, b);
        m_hi[sel] = p[63:32];
        m_lo[sel] = p[31:0];
    endtask

    // fmode: 0 none, 1 flush before handshake, 2 flush with handshake, 3 flush while waiting.
    task automatic div_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int rdy_dly, input int resp_dly, input int fmode, input int fat);
        logic [63:0] rq;
        bit draining;
`ifdef MULDIV_DIVZERO_BYPASS_EN
        if (b == 32'd0) begin
            quiet();
            op_valid = 1'b1;
            op_type = sgn ? 3'd2 : 3'd3;
            op_src1 = a;
            op_src2 = b;
            expect_c(1'b1, 1'b1, 1'b0, 1'b0);
            step();
            m_hi[sel] = a;
            m_lo[sel] = 32'hFFFF_FFFF;
            return;
        end
`endif
        rq = divres(sgn, a, b);
        draining = 1'b0;
        quiet();
        op_valid = 1'b1;
        op_type = sgn ? 3'd2 : 3'd3;
        op_src1 = a;
        op_src2 = b;
        e_dvd = a;
        e_dvs = b;
        e_sgn = sgn;
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        for (int j = 0; j <= rdy_dly; j++) begin
            quiet();
            div_resp_valid = 1'($urandom());
            div_req_ready = (j == rdy_dly);
            if (fmode == 1 && j == fat) begin
                div_req_ready = 1'b0;
                flush = 1'b1;
                expect_c(1'b0, 1'b0, 1'b1, 1'b1);
                step();
                return;
            end
            if (fmode == 2 && j == rdy_dly) begin
                flush = 1'b1;
                draining = 1'b1;
            end
            expect_c(1'b0, 1'b0, 1'b1, 1'b1);
            step();
        end
        for (int w = 1; w <= resp_dly; w++) begin
            quiet();
            div_req_ready = 1'($urandom());
            if (fmode == 3 && w == fat) begin
                flush = 1'b1;
                draining = 1'b1;
            end else if (draining && w < resp_dly) begin
                flush = 1'($urandom());
            end
            if (w == resp_dly) begin
                div_resp_valid = 1'b1;
                div_quot = rq[31:0];
                div_rem = rq[63:32];
            end
            expect_c(1'b0, (w == resp_dly) && !draining, 1'b1, 1'b0);
            step();
        end
        if (!draining) begin
            m_lo[sel] = rq[31:0];
            m_hi[sel] = rq[63:32];
        end
    endtask

    task automatic clear_model();
        for (int g = 0; g < 3; g++) begin
            m_hi[g] = 32'd0;
            m_lo[g] = 32'd0;
        end
    endtask

    task automatic reset_mid_mul();
        quiet();
        op_valid = 1'b1;
        op_type = 3'd0;
        op_src1 = 32'h0001_2345;
        op_src2 = 32'h0000_0777;
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        quiet();
        reset = 1'b1;
        clear_model();
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        idle_cycle(1'b0);
    endtask

    task automatic reset_mid_div();
        quiet();
        op_valid = 1'b1;
        op_type = 3'd3;
        op_src1 = 32'd1000;
        op_src2 = 32'd7;
        e_dvd = 32'd1000;
        e_dvs = 32'd7;
        e_sgn = 1'b0;
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        quiet();
        div_req_ready = 1'b1;
        expect_c(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        quiet();
        reset = 1'b1;
        clear_model();
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        quiet();
        div_resp_valid = 1'b1;
        div_quot = 32'd142;
        div_rem = 32'd6;
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        int kind, rdy, rsp, fm, fat;
        logic [31:0] a, b;
        sel = 0;
        reset = 1'b1;
        quiet();
        clear_model();
        expect_c(1'b1, 1'b0, 1'b0, 1'b0);
        e_dvd = 32'd0;
        e_dvs = 32'd0;
        e_sgn = 1'b0;
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        idle_cycle(1'b0);

        // Signed multiply of -3 by 5, latency 2.
        sel = 1;
        mul_op(1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        cmp("t1_hi", d_hi, 32'hFFFF_FFFF);
        cmp("t1_lo", d_lo, 32'hFFFF_FFF1);

        // Unsigned multiply at each latency.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            mul_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0);
            cmp("t2_hi", d_hi, 32'd1);
            cmp("t2_lo", d_lo, 32'hFFFF_FFFE);
            idle_cycle(1'b0);
        end

        // Signed divide -7 / 2 with a slow divider.
        sel = 1;
        div_op(1'b1, 32'hFFFF_FFF9, 32'd2, 3, 10, 0, 0);
        cmp("t3_lo", d_lo, 32'hFFFF_FFFD);
        cmp("t3_hi", d_hi, 32'hFFFF_FFFF);
        idle_cycle(1'b0);

        // Flushed divu drains its response without touching HI/LO.
        div_op(1'b0, 32'd100, 32'd7, 1, 5, 3, 2);
        idle_cycle(1'b0);
        cmp("t4_lo", d_lo, 32'hFFFF_FFFD);
        cmp("t4_hi", d_hi, 32'hFFFF_FFFF);

        // Back-to-back moves, then a blocked accept under flush.
        single_op(3'd4, 32'h1234_5678, 32'd0);
        single_op(3'd5, 32'h9ABC_DEF0, 32'd0);
        cmp("t5_hi", d_hi, 32'h1234_5678);
        cmp("t5_lo", d_lo, 32'h9ABC_DEF0);
        quiet();
        op_valid = 1'b1;
        op_type = 3'd4;
        op_src1 = 32'hDEAD_BEEF;
        flush = 1'b1;
        expect_c(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        single_op(3'd6, 32'h1111_1111, 32'd0);
        single_op(3'd7, 32'h2222_2222, 32'd0);
        cmp("t5_hold_hi", d_hi, 32'h1234_5678);

        sel = 2;
        reset_mid_mul();
        cmp("t5_rst_hi", d_hi, 32'd0);
        cmp("t5_rst_lo", d_lo, 32'd0);
        sel = 0;
        reset_mid_div();
        cmp("t5_rdiv_lo", d_lo, 32'd0);

        // Zero divisor.
        div_op(1'b0, 32'h0000_0055, 32'd0, 2, 3, 0, 0);
`ifdef MULDIV_DIVZERO_BYPASS_EN
        cmp("t6_hi", d_hi, 32'h0000_0055);
        cmp("t6_lo", d_lo, 32'hFFFF_FFFF);
`else
        cmp("t6_hi", d_hi, 32'h5A5A_5A0F);
        cmp("t6_lo", d_lo, 32'hFFFF_FFAA);
`endif
        idle_cycle(1'b0);

        // Randomized traffic on all three instances.
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(2, 0);
            kind = $urandom_range(9, 0);
            a = rnd32();
            b = rnd32();
            if (kind <= 2) begin
                mul_op(1'($urandom()), a, b,
                       ($urandom_range(3, 0) == 0) ? $urandom_range(lat_of(sel), 1) : 0);
            end else if (kind <= 6) begin
                rdy = $urandom_range(4, 0);
                rsp = $urandom_range(6, 1);
                fm = $urandom_range(3, 0);
                fat = 0;
                if (fm == 1) begin
                    if (rdy == 0) fm = 0;
                    else fat = $urandom_range(rdy - 1, 0);
                end else if (fm == 3) begin
                    if (rsp < 2) fm = 0;
                    else fat = $urandom_range(rsp - 1, 1);
                end
                div_op(1'($urandom()), a, b, rdy, rsp, fm, fat);
            end else begin
                single_op(3'($urandom_range(7, 4)), a, b);
            end
            for (int g = $urandom_range(2, 0); g > 0; g--) idle_cycle(1'b1);
        end

        idle_cycle(1'b0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
